// File: rtl/mix_col_engine.sv
// AES MixColumns / InvMixColumns engine over a 128-bit state.
// It mixes COLS_PER_CYCLE columns per CALC cycle and uses valid/ready handshakes on both sides.
module mix_col_engine #(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int NCALC = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] IDX_STEP = 2'(COLS_PER_CYCLE);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4) ||
        (NCALC * COLS_PER_CYCLE != 4)) begin : g_illegal_cols
        $fatal(1, "mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t       state;
    logic [1:0]   col_idx;
    logic         inv;
    logic [127:0] work;
    logic [127:0] next_work;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic mode_inv);
        logic [7:0]  x  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [1:0]  i0, i1, i2, i3;
        logic [31:0] res;
        res = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            x[r]  = col[31 - 8*r -: 8];
            x2[r] = xt(x[r]);
            x4[r] = xt(x2[r]);
            x8[r] = xt(x4[r]);
        end
        for (int unsigned r = 0; r < 4; r++) begin
            i0 = 2'(r);
            i1 = i0 + 2'd1;
            i2 = i0 + 2'd2;
            i3 = i0 + 2'd3;
            if (mode_inv)
                res[31 - 8*r -: 8] = (x8[i0] ^ x4[i0] ^ x2[i0]) ^ (x8[i1] ^ x2[i1] ^ x[i1]) ^
                                     (x8[i2] ^ x4[i2] ^ x[i2])  ^ (x8[i3] ^ x[i3]);
            else
                res[31 - 8*r -: 8] = x2[i0] ^ (x2[i1] ^ x[i1]) ^ x[i2] ^ x[i3];
        end
        return res;
    endfunction

    // Each column depends only on itself, so the work register is mixed in place.
    always_comb begin
        logic [1:0] c;
        c = '0;
        next_work = work;
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
            c = col_idx + 2'(k);
            next_work[127 - 32*int'(c) -: 32] = mix_col(work[127 - 32*int'(c) -: 32], inv);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            col_idx   <= '0;
            inv       <= 1'b0;
            work      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work     <= in_data;
                        inv      <= in_inv;
                        col_idx  <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    work    <= next_work;
                    col_idx <= col_idx + IDX_STEP;
                    if (col_idx == LAST_IDX) begin
                        out_data  <= next_work;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
